mem_lsu: RTL and testbench

Load/store unit for the pipelined RiSC-16 core: the initiator side of the data-memory port. It accepts one load or store request at a time from the memory stage over a valid/ready handshake and drives the synchronous-read data memory (write on posedge, registered read data one cycle later). It returns a registered response over a second valid/ready handshake. It sits between the MEM pipeline stage and `mem_data`.

---
 rtl/mem_lsu_if.sv | 26 ++
 rtl/mem_lsu.sv | 113 +++++++++++
 tb/tb_mem_lsu.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request/response handshake bundle between the MEM pipeline stage and the load/store unit.
// master = pipeline side (issues requests, consumes responses); slave = mem_lsu.
interface mem_lsu_if #(
   parameter int p_WORD_LEN     = 16,
   parameter int p_CPU_ADDR_LEN = 16
);
   logic                      i_req_valid;
   logic                      o_req_ready;
   logic                      i_req_we;
   logic [p_CPU_ADDR_LEN-1:0] i_req_addr;
   logic [p_WORD_LEN-1:0]     i_req_wdata;
   logic                      o_rsp_valid;
   logic                      i_rsp_ready;
   logic [p_WORD_LEN-1:0]     o_rsp_rdata;
   logic                      o_rsp_err;

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit driving a synchronous-read data memory (3 edges accept->response).
// Optional MEM_LSU_BOUNDS_CHECK_EN flags and suppresses accesses above 2**p_ADDR_LEN words.
module mem_lsu #(
   parameter int p_WORD_LEN     = 16,
   parameter int p_ADDR_LEN     = 10,
   parameter int p_CPU_ADDR_LEN = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   mem_lsu_if.slave              bus,
   output logic                  o_mem_wr_en,
   output logic [p_ADDR_LEN-1:0] o_mem_addr,
   output logic [p_WORD_LEN-1:0] o_mem_wr_data,
   input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
   output logic                  o_busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                state_q, state_d;
   logic                  we_q, we_d;
   logic [p_ADDR_LEN-1:0] addr_q, addr_d;
   logic [p_WORD_LEN-1:0] wdata_q, wdata_d;
   logic [p_WORD_LEN-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  req_ready;
   logic                  rsp_valid;
   logic                  mem_wr_en;
   logic                  accept;
   logic                  req_err;

`ifdef MEM_LSU_BOUNDS_CHECK_EN
   assign req_err = |bus.i_req_addr[p_CPU_ADDR_LEN-1:p_ADDR_LEN];
`else
   // Upper address bits are deliberately dropped: addresses alias modulo memory size.
   logic unused_addr_hi;
   assign unused_addr_hi = |bus.i_req_addr[p_CPU_ADDR_LEN-1:p_ADDR_LEN];
   assign req_err        = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_wr_en = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         ISSUE: begin
            mem_wr_en = we_q & ~err_q;
            state_d   = WAIT;
         end
         WAIT: begin
            rdata_d = err_q ? '0 : i_mem_rd_data;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            req_ready = bus.i_rsp_ready;
            if (bus.i_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new request may enter from IDLE or on the same edge the response is consumed.
      accept = bus.i_req_valid & req_ready;
      if (accept) begin
         we_d    = bus.i_req_we;
         addr_d  = bus.i_req_addr[p_ADDR_LEN-1:0];
         wdata_d = bus.i_req_wdata;
         err_d   = req_err;
         state_d = ISSUE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.o_req_ready = req_ready;
   assign bus.o_rsp_valid = rsp_valid;
   assign bus.o_rsp_rdata = rdata_q;
   assign bus.o_rsp_err   = err_q;
   assign o_mem_wr_en     = mem_wr_en;
   assign o_mem_addr      = addr_q;
   assign o_mem_wr_data   = wdata_q;
   assign o_busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural synchronous-read memory.
module tb_mem_lsu;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_lsu_if #(.p_WORD_LEN(16), .p_CPU_ADDR_LEN(16)) bus ();

   logic        mem_wr_en;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wr_data;
   logic [15:0] mem_rd_data;
   logic        busy;

   mem_lsu #(.p_WORD_LEN(16), .p_ADDR_LEN(10), .p_CPU_ADDR_LEN(16)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .bus           (bus),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_addr    (mem_addr),
      .o_mem_wr_data (mem_wr_data),
      .i_mem_rd_data (mem_rd_data),
      .o_busy        (busy)
   );

   // Read-before-write synchronous memory
   logic [15:0] mem [0:1023] = '{default: 16'h0000};
   always @(posedge clk) begin
      mem_rd_data <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
   end

   int checks = 0;
   int errors = 0;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output logic er, output int lat, output int wrs);
      int n;
      lat = 0; wrs = 0; rd = '0; er = 1'b0;
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_req_we = we; bus.i_req_addr = a; bus.i_req_wdata = wd;
      bus.i_rsp_ready = 1'b0;
      n = 0;
      while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1 bus.i_req_valid = 1'b0;
      while (lat < 10) begin
         @(negedge clk); lat++;
         if (mem_wr_en) wrs++;
         if (bus.o_rsp_valid) break;
      end
      rd = bus.o_rsp_rdata; er = bus.o_rsp_err;
      bus.i_rsp_ready = 1'b1;
      @(posedge clk); #1 bus.i_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
      bus.i_rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.o_rsp_valid); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.o_req_ready); end
      checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
      checks++; if (mem_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data got %h want 0000", mem_wr_data); end
      checks++; if (bus.o_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0000", bus.o_rsp_rdata); end
      checks++; if (bus.o_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.o_rsp_err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store();
      logic [15:0] rd; logic er; int lat; int wrs;
      do_req(1'b1, 16'h0005, 16'hBEEF, rd, er, lat, wrs);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
      checks++; if (wrs !== 1) begin errors++; $display("FAIL store_wr_cycles got %0d want 1", wrs); end
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL store_rdata got %h want 0000", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
      checks++; if (mem[5] !== 16'hBEEF) begin errors++; $display("FAIL store_mem5 got %h want beef", mem[5]); end
   endtask

   task automatic test_load();
      logic [15:0] rd; logic er; int lat; int wrs;
      do_req(1'b0, 16'h0005, 16'h0000, rd, er, lat, wrs);
      checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
      checks++; if (wrs !== 0) begin errors++; $display("FAIL load_wr_cycles got %0d want 0", wrs); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL load_rdata got %h want beef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", er); end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 16'h0005; bus.i_req_wdata = '0;
      bus.i_rsp_ready = 1'b0;
      n = 0;
      while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      // Pending store stays offered throughout the stall and must be ignored
      bus.i_req_we = 1'b1; bus.i_req_addr = 16'h0007; bus.i_req_wdata = 16'h7777;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.o_rsp_valid && n < 10);
      checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got %b want 1", bus.o_rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.o_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, bus.o_rsp_valid); end
         checks++; if (bus.o_rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL bp_hold_rdata[%0d] got %h want beef", i, bus.o_rsp_rdata); end
         checks++; if (bus.o_req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready[%0d] got %b want 0", i, bus.o_req_ready); end
         checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL bp_hold_wr_en[%0d] got %b want 0", i, mem_wr_en); end
         if (i < 4) @(negedge clk);
      end
      bus.i_rsp_ready = 1'b1; #1;
      checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got %b want 1", bus.o_req_ready); end
      @(posedge clk); #1 bus.i_rsp_ready = 1'b0; bus.i_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL bp_new_issue_wr_en got %b want 1", mem_wr_en); end
      checks++; if (mem_addr !== 10'h007) begin errors++; $display("FAIL bp_new_issue_addr got %h want 007", mem_addr); end
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_new_issue_rsp_valid got %b want 0", bus.o_rsp_valid); end
      n = 0;
      while (!bus.o_rsp_valid && n < 10) begin @(negedge clk); n++; end
      checks++; if (bus.o_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL bp_new_rdata got %h want 0000", bus.o_rsp_rdata); end
      bus.i_rsp_ready = 1'b1;
      @(posedge clk); #1 bus.i_rsp_ready = 1'b0;
      @(negedge clk);
      checks++; if (mem[7] !== 16'h7777) begin errors++; $display("FAIL bp_mem7 got %h want 7777", mem[7]); end
   endtask

   task automatic test_back_to_back();
      logic        t_we   [4];
      logic [15:0] t_addr [4];
      logic [15:0] t_wd   [4];
      logic [15:0] rsp    [4];
      int          acyc   [4];
      int          rcyc   [4];
      int idx, nrsp, cyc;
      logic acc;
      t_we[0] = 1'b1; t_addr[0] = 16'h0001; t_wd[0] = 16'h1111;
      t_we[1] = 1'b1; t_addr[1] = 16'h0002; t_wd[1] = 16'h2222;
      t_we[2] = 1'b0; t_addr[2] = 16'h0001; t_wd[2] = 16'h0000;
      t_we[3] = 1'b0; t_addr[3] = 16'h0002; t_wd[3] = 16'h0000;
      for (int k = 0; k < 4; k++) begin rsp[k] = 16'hXXXX; acyc[k] = 0; rcyc[k] = 0; end
      idx = 0; nrsp = 0; cyc = 0;
      @(negedge clk);
      bus.i_rsp_ready = 1'b1; bus.i_req_valid = 1'b1;
      bus.i_req_we = t_we[0]; bus.i_req_addr = t_addr[0]; bus.i_req_wdata = t_wd[0];
      while ((idx < 4 || nrsp < 4) && cyc < 60) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         acc = bus.o_req_ready & bus.i_req_valid;
         if (bus.o_rsp_valid && nrsp < 4) begin rsp[nrsp] = bus.o_rsp_rdata; rcyc[nrsp] = cyc; nrsp++; end
         if (acc) acyc[idx] = cyc;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               bus.i_req_we = t_we[idx]; bus.i_req_addr = t_addr[idx]; bus.i_req_wdata = t_wd[idx];
            end else begin
               bus.i_req_valid = 1'b0;
            end
         end
      end
      bus.i_rsp_ready = 1'b0;
      checks++; if (nrsp !== 4) begin errors++; $display("FAIL b2b_rsp_count got %0d want 4", nrsp); end
      checks++; if (acyc[1] - acyc[0] !== 3) begin errors++; $display("FAIL b2b_gap01 got %0d want 3", acyc[1] - acyc[0]); end
      checks++; if (acyc[2] - acyc[1] !== 3) begin errors++; $display("FAIL b2b_gap12 got %0d want 3", acyc[2] - acyc[1]); end
      checks++; if (acyc[3] - acyc[2] !== 3) begin errors++; $display("FAIL b2b_gap23 got %0d want 3", acyc[3] - acyc[2]); end
      checks++; if (rcyc[3] - acyc[3] !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", rcyc[3] - acyc[3]); end
      checks++; if (rsp[0] !== 16'h0000) begin errors++; $display("FAIL b2b_st1_rdata got %h want 0000", rsp[0]); end
      checks++; if (rsp[1] !== 16'h0000) begin errors++; $display("FAIL b2b_st2_rdata got %h want 0000", rsp[1]); end
      checks++; if (rsp[2] !== 16'h1111) begin errors++; $display("FAIL b2b_ld1_rdata got %h want 1111", rsp[2]); end
      checks++; if (rsp[3] !== 16'h2222) begin errors++; $display("FAIL b2b_ld2_rdata got %h want 2222", rsp[3]); end
   endtask

   task automatic test_bounds();
      logic [15:0] rd; logic er; int lat; int wrs;
      do_req(1'b1, 16'h0405, 16'h1234, rd, er, lat, wrs);
      @(negedge clk);
      checks++; if (lat !== 3) begin errors++; $display("FAIL bounds_latency got %0d want 3", lat); end
`ifdef MEM_LSU_BOUNDS_CHECK_EN
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL bounds_err got %b want 1", er); end
      checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL bounds_rdata got %h want 0000", rd); end
      checks++; if (wrs !== 0) begin errors++; $display("FAIL bounds_wr_cycles got %0d want 0", wrs); end
      checks++; if (mem[5] !== 16'hBEEF) begin errors++; $display("FAIL bounds_mem5 got %h want beef", mem[5]); end
`else
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL bounds_err got %b want 0", er); end
      checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL bounds_rdata got %h want beef", rd); end
      checks++; if (wrs !== 1) begin errors++; $display("FAIL bounds_wr_cycles got %0d want 1", wrs); end
      checks++; if (mem[5] !== 16'h1234) begin errors++; $display("FAIL bounds_mem5 got %h want 1234", mem[5]); end
`endif
   endtask

   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_addr = 16'h0009; bus.i_req_wdata = 16'h5555;
      bus.i_rsp_ready = 1'b0;
      n = 0;
      while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1 bus.i_req_valid = 1'b0;
      checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL rmid_issue_wr_en got %b want 1", mem_wr_en); end
      rst_n = 1'b0; #1;
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en got %b want 0", mem_wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid got %b want 0", bus.o_rsp_valid); end
      checks++; if (bus.o_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_req_ready got %b want 1", bus.o_req_ready); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (bus.o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_rsp_valid got %b want 0", bus.o_rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy got %b want 0", busy); end
      checks++; if (mem[9] !== 16'h0000) begin errors++; $display("FAIL rmid_mem9 got %h want 0000", mem[9]); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_backpressure();
      test_back_to_back();
      test_bounds();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
